// File: rtl/jbi_pktout_int_arb_pkg.sv
// ----------------------------------------------------------------------------
// jbi_pktout_int_arb_pkg
//
// Shared definitions for the JBus output-path internal arbiter:
//   - T_*      : 4-bit head-packet type codes (same values as the packet
//                controller's header definitions)
//   - LRQ_*    : index / bit position of each outbound queue in the
//                int_requestors vector
//   - arb_state_e : arbitration FSM state encodings
//   - rr_next  : wrap-around successor for the 5-entry round-robin pointer
// ----------------------------------------------------------------------------
package jbi_pktout_int_arb_pkg;

    typedef logic [3:0] pkt_type_t;

    localparam pkt_type_t T_NONE       = 4'd0;
    localparam pkt_type_t T_RD16       = 4'd1;
    localparam pkt_type_t T_RD64       = 4'd2;
    localparam pkt_type_t T_NCRD       = 4'd3;
    localparam pkt_type_t T_NCWR0      = 4'd4;
    localparam pkt_type_t T_NCWR4      = 4'd5;
    localparam pkt_type_t T_NCWR5      = 4'd6;
    localparam pkt_type_t T_NCWR_OTHER = 4'd7;
    localparam pkt_type_t T_INTACK     = 4'd8;
    localparam pkt_type_t T_INTNACK    = 4'd9;
    localparam pkt_type_t T_RDER       = 4'd10;

    localparam int LRQ_SCT0_BIT    = 0;
    localparam int LRQ_SCT1_BIT    = 1;
    localparam int LRQ_SCT2_BIT    = 2;
    localparam int LRQ_SCT3_BIT    = 3;
    localparam int LRQ_PIORQQ_BIT  = 4;
    localparam int LRQ_PIOACKQ_BIT = 5;
    localparam int LRQ_DBGQ_BIT    = 6;

    localparam int LRQ_NUM = 7;
    localparam int RR_NUM  = 5;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_HOLD = 2'd1,
        ARB_GAP  = 2'd2
    } arb_state_e;

    // Successor of a round-robin slot, wrapping PIORQQ back to SCT0.
    function automatic logic [2:0] rr_next(input logic [2:0] idx);
        return (idx == 3'(RR_NUM - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/jbi_pktout_int_arb_if.sv
// ----------------------------------------------------------------------------
// jbi_pktout_int_arb_if
//
// Bundles the queue-side request bus and the controller-side grant/selection
// signals of the internal arbiter.
//   <q>_req       : queue non-empty
//   <q>_type      : head packet type (T_* code)
//   <q>_complete  : all data beats of the head packet present
//   int_granted   : one-cycle accept pulse from the packet controller
//   int_requestors: one-hot selected queue (LRQ_*_BIT positions)
//   int_req_type  : type of the selected head, T_NONE when idle
//   multiple_ok   : complete flag of the selected queue
// Modports: master = queues + controller (drive requests and grants),
//           slave  = arbiter.
// ----------------------------------------------------------------------------
interface jbi_pktout_int_arb_if;
    import jbi_pktout_int_arb_pkg::*;

    logic       sct0rdq_req, sct1rdq_req, sct2rdq_req, sct3rdq_req;
    logic       piorqq_req, pioackq_req, dbgq_req;
    pkt_type_t  sct0rdq_type, sct1rdq_type, sct2rdq_type, sct3rdq_type;
    pkt_type_t  piorqq_type, pioackq_type, dbgq_type;
    logic       sct0rdq_complete, sct1rdq_complete, sct2rdq_complete;
    logic       sct3rdq_complete, piorqq_complete, pioackq_complete;
    logic       dbgq_complete;
    logic       int_granted;
    logic [6:0] int_requestors;
    pkt_type_t  int_req_type;
    logic       multiple_ok;

    modport master (
        output sct0rdq_req, sct1rdq_req, sct2rdq_req, sct3rdq_req,
               piorqq_req, pioackq_req, dbgq_req,
               sct0rdq_type, sct1rdq_type, sct2rdq_type, sct3rdq_type,
               piorqq_type, pioackq_type, dbgq_type,
               sct0rdq_complete, sct1rdq_complete, sct2rdq_complete,
               sct3rdq_complete, piorqq_complete, pioackq_complete,
               dbgq_complete, int_granted,
        input  int_requestors, int_req_type, multiple_ok
    );

    modport slave (
        input  sct0rdq_req, sct1rdq_req, sct2rdq_req, sct3rdq_req,
               piorqq_req, pioackq_req, dbgq_req,
               sct0rdq_type, sct1rdq_type, sct2rdq_type, sct3rdq_type,
               piorqq_type, pioackq_type, dbgq_type,
               sct0rdq_complete, sct1rdq_complete, sct2rdq_complete,
               sct3rdq_complete, piorqq_complete, pioackq_complete,
               dbgq_complete, int_granted,
        output int_requestors, int_req_type, multiple_ok
    );

endinterface

// File: rtl/jbi_pktout_rr5.sv
// ----------------------------------------------------------------------------
// jbi_pktout_rr5
//
// 5-way round-robin picker over SCT0..SCT3 and PIORQQ.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (pointer -> slot 0)
//   req       : request mask, one bit per slot
//   advance   : move the pointer past the slot named in adv_sel
//   adv_sel   : one-hot slot that was actually granted
//   grant     : one-hot combinational pick, searching upward from the pointer
// ----------------------------------------------------------------------------
module jbi_pktout_rr5
    import jbi_pktout_int_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] req,
    input  logic       advance,
    input  logic [4:0] adv_sel,
    output logic [4:0] grant
);

    logic [2:0] ptr;
    logic [2:0] adv_idx;
    logic [3:0] sum;
    logic [2:0] idx;
    logic       found;

    // Search the five slots starting at the pointer; the first requester wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int off = 0; off < RR_NUM; off++) begin
            sum = {1'b0, ptr} + 4'(off);
            if (sum >= 4'(RR_NUM)) begin
                sum = sum - 4'(RR_NUM);
            end
            idx = sum[2:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // The granted slot comes from the arbiter's frozen selection, not from
    // the live pick, since requests may have changed while it was held.
    always_comb begin
        adv_idx = '0;
        for (int i = 0; i < RR_NUM; i++) begin
            if (adv_sel[i]) begin
                adv_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= rr_next(adv_idx);
        end
    end

endmodule

// File: rtl/jbi_pktout_int_arb.sv
// ----------------------------------------------------------------------------
// jbi_pktout_int_arb
//
// Internal arbiter for the JBus output path. Picks one of seven outbound
// queues (SCT0-3 RDQ, PIO RQQ, PIO ACKQ, DBGQ) and holds it on int_requestors
// until the packet controller pulses int_granted, then inserts a one-cycle
// idle bubble so a stale head is never re-presented.
//
// Priority: promoted DBGQ > PIOACKQ > round-robin(SCT0..3, PIORQQ) > DBGQ.
//
// Ports:
//   clk  : JBus clock
//   rst  : synchronous active-high reset
//   arb  : jbi_pktout_int_arb_if.slave (queue requests, grant, selection)
// Parameters:
//   DBG_STARVE_MAX : grants to other queues before a waiting DBGQ is
//                    promoted (must be >= 1)
// Build option:
//   JBI_PKTOUT_ARB_DBGQ_EN : when defined, DBGQ arbitrates and the
//                    starvation counter is built; otherwise DBGQ inputs are
//                    ignored and its int_requestors bit is constant 0.
// ----------------------------------------------------------------------------
module jbi_pktout_int_arb
    import jbi_pktout_int_arb_pkg::*;
#(
    parameter int DBG_STARVE_MAX = 15
) (
    input  logic                clk,
    input  logic                rst,
    jbi_pktout_int_arb_if.slave arb
);

    if (DBG_STARVE_MAX < 1) begin : g_bad_starve_max
        $error("DBG_STARVE_MAX must be at least 1");
    end

    arb_state_e state;
    logic [6:0] req_vec;
    logic [6:0] comp_vec;
    pkt_type_t  type_vec [LRQ_NUM];
    logic [6:0] req_q;
    logic [6:0] sel;
    logic [4:0] rr_grant;
    logic       grant_ok;
    logic       held_req;
    logic       dbg_promoted;
    pkt_type_t  type_o;
    logic       mo_o;

    assign req_vec[LRQ_SCT0_BIT]    = arb.sct0rdq_req;
    assign req_vec[LRQ_SCT1_BIT]    = arb.sct1rdq_req;
    assign req_vec[LRQ_SCT2_BIT]    = arb.sct2rdq_req;
    assign req_vec[LRQ_SCT3_BIT]    = arb.sct3rdq_req;
    assign req_vec[LRQ_PIORQQ_BIT]  = arb.piorqq_req;
    assign req_vec[LRQ_PIOACKQ_BIT] = arb.pioackq_req;

    assign type_vec[LRQ_SCT0_BIT]    = arb.sct0rdq_type;
    assign type_vec[LRQ_SCT1_BIT]    = arb.sct1rdq_type;
    assign type_vec[LRQ_SCT2_BIT]    = arb.sct2rdq_type;
    assign type_vec[LRQ_SCT3_BIT]    = arb.sct3rdq_type;
    assign type_vec[LRQ_PIORQQ_BIT]  = arb.piorqq_type;
    assign type_vec[LRQ_PIOACKQ_BIT] = arb.pioackq_type;

    assign comp_vec[LRQ_SCT0_BIT]    = arb.sct0rdq_complete;
    assign comp_vec[LRQ_SCT1_BIT]    = arb.sct1rdq_complete;
    assign comp_vec[LRQ_SCT2_BIT]    = arb.sct2rdq_complete;
    assign comp_vec[LRQ_SCT3_BIT]    = arb.sct3rdq_complete;
    assign comp_vec[LRQ_PIORQQ_BIT]  = arb.piorqq_complete;
    assign comp_vec[LRQ_PIOACKQ_BIT] = arb.pioackq_complete;

    // A grant only counts while a selection is actually presented.
    assign grant_ok = (state == ARB_HOLD) && arb.int_granted;
    assign held_req = |(req_q & req_vec);

    jbi_pktout_rr5 u_rr5 (
        .clk     (clk),
        .rst     (rst),
        .req     (req_vec[4:0]),
        .advance (grant_ok && (|req_q[4:0])),
        .adv_sel (req_q[4:0]),
        .grant   (rr_grant)
    );

`ifdef JBI_PKTOUT_ARB_DBGQ_EN
    localparam int CNT_W = $clog2(DBG_STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DBG_STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;

    assign req_vec[LRQ_DBGQ_BIT]  = arb.dbgq_req;
    assign type_vec[LRQ_DBGQ_BIT] = arb.dbgq_type;
    assign comp_vec[LRQ_DBGQ_BIT] = arb.dbgq_complete;

    // Counts grants that bypassed a waiting DBGQ; saturates at the limit so
    // the promotion stays asserted until DBGQ itself is served.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!arb.dbgq_req) begin
            starve_cnt <= '0;
        end else if (grant_ok) begin
            if (req_q[LRQ_DBGQ_BIT]) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    assign dbg_promoted = (starve_cnt == CNT_MAX);
`else
    logic unused_dbgq;

    assign req_vec[LRQ_DBGQ_BIT]  = 1'b0;
    assign type_vec[LRQ_DBGQ_BIT] = T_NONE;
    assign comp_vec[LRQ_DBGQ_BIT] = 1'b0;
    assign dbg_promoted           = 1'b0;
    assign unused_dbgq = ^{arb.dbgq_req, arb.dbgq_type, arb.dbgq_complete};
`endif

    // Fixed-priority wrapper around the round-robin group.
    always_comb begin
        sel = '0;
        if (dbg_promoted && req_vec[LRQ_DBGQ_BIT]) begin
            sel[LRQ_DBGQ_BIT] = 1'b1;
        end else if (req_vec[LRQ_PIOACKQ_BIT]) begin
            sel[LRQ_PIOACKQ_BIT] = 1'b1;
        end else if (|req_vec[4:0]) begin
            sel[4:0] = rr_grant;
        end else if (req_vec[LRQ_DBGQ_BIT]) begin
            sel[LRQ_DBGQ_BIT] = 1'b1;
        end
    end

    // Arbitration FSM. req_q is the registered selection and reads zero in
    // IDLE and GAP, so the outputs naturally idle outside HOLD. A grant
    // beats both a dropped request and a newly arriving one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
            req_q <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|req_vec) begin
                        state <= ARB_HOLD;
                        req_q <= sel;
                    end
                end
                ARB_HOLD: begin
                    if (arb.int_granted) begin
                        state <= ARB_GAP;
                        req_q <= '0;
                    end else if (!held_req) begin
                        state <= ARB_IDLE;
                        req_q <= '0;
                    end
                end
                ARB_GAP: begin
                    if (|req_vec) begin
                        state <= ARB_HOLD;
                        req_q <= sel;
                    end else begin
                        state <= ARB_IDLE;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    req_q <= '0;
                end
            endcase
        end
    end

    // Type and complete follow the frozen queue's live head while held.
    always_comb begin
        type_o = T_NONE;
        mo_o   = 1'b0;
        for (int i = 0; i < LRQ_NUM; i++) begin
            if (req_q[i]) begin
                type_o = type_vec[i];
                mo_o   = comp_vec[i];
            end
        end
    end

    assign arb.int_requestors = req_q;
    assign arb.int_req_type   = type_o;
    assign arb.multiple_ok    = mo_o;

    // Protocol monitors: selection shape, stray grants, and a held queue
    // emptying without being granted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(req_q));
            assert (!(arb.int_granted && (state != ARB_HOLD)));
            assert (!((state == ARB_HOLD) && !arb.int_granted && !held_req));
        end
    end

endmodule

// File: doc/jbi_pktout_int_arb.md
# jbi_pktout_int_arb

Internal arbiter for the JBus output path: it picks one of seven outbound queues per packet and presents that queue to the packet controller. The queues are the four SCTnRDQ return queues, PIO RQQ, PIO ACKQ and DBGQ. For the selected queue it drives the one-hot `int_requestors`, the 4-bit `int_req_type` and `multiple_ok`. It holds that selection until the controller returns `int_granted`.

## Interface
Parameters:
- DBG_STARVE_MAX, 15: number of grants to other queues after which a waiting DBGQ is promoted to top priority.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  JBus clock.
- rst  in  1  synchronous, active-high reset.
- sct0rdq_req … sct3rdq_req, piorqq_req, pioackq_req, dbgq_req  in  1 each  queue non-empty.
- sct0rdq_type … dbgq_type  in  4 each  head packet type; T_* encoding from the package.
- sct0rdq_complete … dbgq_complete  in  1 each  all data beats of the head packet are present.
- int_granted  in  1  one-cycle pulse: the controller accepted the presented request.
- int_requestors  out  7  one-hot selected queue; bit positions are LRQ_*_BIT.
- int_req_type  out  4  type of the selected head; T_NONE when idle.
- multiple_ok  out  1  `*_complete` of the selected queue.

## Operation
- Arbitration FSM with three states:
  - IDLE: no selection is presented.
  - HOLD: a selection is presented.
  - GAP: one-cycle post-grant bubble.
- IDLE → HOLD when any enabled `*_req` is asserted; the winner is registered.
- HOLD → GAP on `int_granted`. In GAP, outputs read as idle, so a stale head is never re-presented before the dequeue takes effect.
- GAP → HOLD if a request is pending, else GAP → IDLE.
- In HOLD:
  - `int_requestors` and the winner identity are frozen.
  - `int_req_type` and `multiple_ok` track the frozen queue's live inputs.
  - If the frozen queue's `req` drops without a grant, return to IDLE; this is an illegal stimulus and is flagged by a monitor.
- Priority when selecting:
  1. DBGQ, if promoted.
  2. PIOACKQ.
  3. Round-robin over SCT0, SCT1, SCT2, SCT3, PIORQQ. The pointer advances to the entry after the winner, and only on `int_granted`.
  4. DBGQ, otherwise.
- Starvation counter:
  - Saturating, width $clog2(DBG_STARVE_MAX+1).
  - Increments on each `int_granted` to a non-DBGQ queue while `dbgq_req` is set.
  - Clears when DBGQ is granted or `dbgq_req` is low.
  - DBGQ is promoted when the count equals DBG_STARVE_MAX.
- `int_requestors` is always zero or one-hot; a monitor checks this.

## Timing
- Reset values: state IDLE, `int_requestors` 0, `int_req_type` T_NONE (0), `multiple_ok` 0, RR pointer at SCT0, starvation count 0.
- Latency: `req` rising at edge N makes `int_requestors` valid after edge N+1.
- Grant turnaround: `int_granted` at edge N gives idle outputs after N+1 (GAP) and the next selection after N+2. The minimum request-to-request spacing is therefore 2 cycles; the controller's multi-beat states absorb this.
- Simultaneous events:
  - `int_granted` and a new `req` in the same cycle: the grant wins and the new request waits for GAP.
  - `int_granted` while not in HOLD is ignored (monitor flags it).
- Reset asserted mid-HOLD: outputs go to reset values on the next edge, the pointer returns to SCT0 and the count clears.

## Configuration
- `JBI_PKTOUT_ARB_DBGQ_EN`
  - Defined: DBGQ takes part in arbitration, and the starvation counter and promotion are built.
  - Undefined: `dbgq_req`, `dbgq_type` and `dbgq_complete` are ignored, the counter is not instantiated, and the DBGQ bit of `int_requestors` is constant 0.

## Structure
- Shared package: T_* type codes and LRQ_* index and bit constants, reused from the controller's header definitions:
  - T_NONE=0, T_RD16=1, T_RD64=2, T_NCRD=3, T_NCWR0=4, T_NCWR4=5, T_NCWR5=6, T_NCWR_OTHER=7, T_INTACK=8, T_INTNACK=9, T_RDER=10.
  - LRQ bits: SCT0=0, SCT1=1, SCT2=2, SCT3=3, PIORQQ=4, PIOACKQ=5, DBGQ=6.
  - FSM state encodings.
- One sub-module: `jbi_pktout_rr5`, a 5-way round-robin picker (pointer register, request mask, advance enable, one-hot grant).

## Test plan
- Reset, then `sct2rdq_req`=1 with type T_RD64 and complete=1 → after one edge: `int_requestors`=7'b000_0100, `int_req_type`=2, `multiple_ok`=1.
- `pioackq_req` and `sct0rdq_req` both held → PIOACKQ (7'b010_0000) is presented first; after its grant, GAP shows 0, then SCT0 is presented.
- SCT0, SCT1 and PIORQQ held with a grant every HOLD → presentation order SCT0, SCT1, PIORQQ, SCT0, with exactly one zero cycle between presentations.
- DBGQ held while SCT0–3 are continuously requesting, DBG_STARVE_MAX=15 → DBGQ (7'b100_0000) is presented right after the 15th SCT grant.
- `rst` asserted during HOLD of PIORQQ → next edge gives `int_requestors`=0 and type 0; after release, SCT0 wins when SCT0 and PIORQQ both request.
- Build without `JBI_PKTOUT_ARB_DBGQ_EN` and with only `dbgq_req`=1 → `int_requestors` stays 0 for 20 cycles.
